// File: rtl/sysray_feeder.sv
// sysray_feeder -- input skew feeder for a systolic array.
//
// Accepted input vectors are fanned out to the array rows with a per-lane
// delay: lane k of a vector appears on data_o/valid_o exactly k+1 cycles
// after it is accepted. Cycles without an acceptance travel through the
// same delay lines as bubbles (valid low). A small FSM tracks a tile. The
// vector flagged with vec_last_i closes the tile. The FSM then stalls input
// for N cycles (DRAIN) while the skewed tail empties, and pulses done_o in
// the cycle the final lane of the last vector is presented.
//
// Parameters:
//   N  number of array rows / lanes (1..16)
//   W  data element width in bits
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   vec_i        input vector, lane k at [k*W +: W]
//   vec_valid_i  vec_i is valid
//   vec_last_i   final vector of a tile (qualified by vec_valid_i)
//   vec_ready_o  a vector can be accepted this cycle
//   data_o       skewed data to the array rows, lane k at [k*W +: W]
//   valid_o      per-lane valid to the array rows
//   busy_o       a tile is in progress (STREAM or DRAIN)
//   done_o       single-cycle tile completion pulse
//
// Build option:
//   SYSRAY_FEEDER_ZERO_PAD_EN  when defined, a lane's data_o is forced to
//                              zero whenever its valid_o is low.

module sysray_feeder #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N*W-1:0] vec_i,
  input  logic           vec_valid_i,
  input  logic           vec_last_i,
  output logic           vec_ready_o,
  output logic [N*W-1:0] data_o,
  output logic [N-1:0]   valid_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  assign vec_ready_o = (state_q != DRAIN);
  assign accept      = vec_valid_i & vec_ready_o;
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DRAIN is entered with the counter at N-1 and left after the cycle in
  // which it reaches zero, so the last lane of the last vector is on the
  // outputs exactly when done_o fires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (vec_last_i) begin
            state_d = DRAIN;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && vec_last_i) begin
          state_d = DRAIN;
          cnt_d   = CW'(N - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One shift register per lane, depth k+1. Stage 0 holds its data on a
  // bubble so rejected or idle input values never reach the outputs.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [k:0][W-1:0] dat_q, dat_d;
    logic [k:0]        vld_q, vld_d;

    always_comb begin
      dat_d    = dat_q;
      vld_d    = vld_q;
      dat_d[0] = accept ? vec_i[k*W +: W] : dat_q[0];
      vld_d[0] = accept;
      for (int j = 1; j <= k; j++) begin
        dat_d[j] = dat_q[j-1];
        vld_d[j] = vld_q[j-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign valid_o[k] = vld_q[k];
`ifdef SYSRAY_FEEDER_ZERO_PAD_EN
    assign data_o[k*W +: W] = vld_q[k] ? dat_q[k] : '0;
`else
    assign data_o[k*W +: W] = dat_q[k];
`endif
  end

endmodule
